// File: rtl/bofs_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bofs_sequencer_pkg
//   Shared tile-configuration constants for the block-offset sequencer and the
//   state type for its control FSM.
//   WORK_BW     : offset word width
//   DIM         : number of loop dimensions
//   VECTOR_SIZE : lanes per vector
// -----------------------------------------------------------------------------
package bofs_sequencer_pkg;

  localparam int unsigned WORK_BW     = 32;
  localparam int unsigned DIM         = 3;
  localparam int unsigned VECTOR_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bofs_seq_state_t;

endpackage

// File: rtl/bofs_lane_expand.sv
// -----------------------------------------------------------------------------
// bofs_lane_expand
//   Purely combinational expansion of one block offset into VSIZE per-lane
//   offsets, plus a per-lane in-bounds mask.
//   i_en           : when low all outputs are forced to zero
//   i_bofs         : block offset per dimension
//   i_bend         : exclusive boundary per dimension
//   i_subofs       : per-lane, per-dimension sub-offset
//   i_lo_order     : left shift applied to the sub-offset, per dimension
//   o_vector_bofs  : per-lane, per-dimension offset (block | shifted sub-offset)
//   o_lane_valid   : lane is inside the boundary in every dimension
// -----------------------------------------------------------------------------
module bofs_lane_expand #(
  parameter int unsigned WBW    = 32,
  parameter int unsigned DIM    = 3,
  parameter int unsigned VSIZE  = 32,
  parameter int unsigned CV_BW  = 5,
  parameter int unsigned CCV_BW = 3
) (
  input  logic                                  i_en,
  input  logic [DIM-1:0][WBW-1:0]               i_bofs,
  input  logic [DIM-1:0][WBW-1:0]               i_bend,
  input  logic [VSIZE-1:0][DIM-1:0][CV_BW-1:0]  i_subofs,
  input  logic [DIM-1:0][CCV_BW-1:0]            i_lo_order,
  output logic [VSIZE-1:0][DIM-1:0][WBW-1:0]    o_vector_bofs,
  output logic [VSIZE-1:0]                      o_lane_valid
);

  always_comb begin
    logic [WBW-1:0] w_lane_ofs;
    logic           w_in_bounds;
    o_vector_bofs = '0;
    o_lane_valid  = '0;
    w_lane_ofs    = '0;
    w_in_bounds   = 1'b0;
    if (i_en) begin
      for (int unsigned i = 0; i < VSIZE; i++) begin
        w_in_bounds = 1'b1;
        for (int unsigned j = 0; j < DIM; j++) begin
          // Sub-offset is zero-extended to the word width before shifting.
          w_lane_ofs = i_bofs[j] | (WBW'(i_subofs[i][j]) << i_lo_order[j]);
          o_vector_bofs[i][j] = w_lane_ofs;
          w_in_bounds = w_in_bounds & (i_bend[j] > w_lane_ofs);
        end
        o_lane_valid[i] = w_in_bounds;
      end
    end
  end

endmodule

// File: rtl/bofs_sequencer.sv
// -----------------------------------------------------------------------------
// bofs_sequencer
//   Self-running odometer over a DIM-dimensional block-offset space. A job is
//   configured through a valid/ready handshake, then one block is emitted per
//   accepted beat and expanded into VSIZE per-lane offsets.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_cfg_valid       : configuration offered (taken when o_cfg_ready)
//   o_cfg_ready       : sequencer idle
//   i_bstart/i_bend   : first block offset / exclusive boundary per dimension
//   i_bstride         : block step per dimension
//   i_bsubofs         : per-lane sub-offset, i_bsub_lo_order its left shift
//   i_flush           : synchronous abort, wins over beat and configuration
//   o_valid/i_ready   : block beat handshake
//   o_bofs            : current block offset
//   o_lane_valid      : per-lane in-bounds mask
//   o_vector_bofs     : per-lane offsets
//   o_last            : current beat is the final block of the job
//   o_done            : one-cycle pulse after a job completes
// -----------------------------------------------------------------------------
module bofs_sequencer #(
  parameter  int unsigned WBW    = bofs_sequencer_pkg::WORK_BW,
  parameter  int unsigned DIM    = bofs_sequencer_pkg::DIM,
  parameter  int unsigned VSIZE  = bofs_sequencer_pkg::VECTOR_SIZE,
  localparam int unsigned CV_BW  = $clog2(VSIZE),
  localparam int unsigned CCV_BW = $clog2(CV_BW + 1)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_cfg_valid,
  output logic                                  o_cfg_ready,
  input  logic [DIM-1:0][WBW-1:0]               i_bstart,
  input  logic [DIM-1:0][WBW-1:0]               i_bend,
  input  logic [DIM-1:0][WBW-1:0]               i_bstride,
  input  logic [VSIZE-1:0][DIM-1:0][CV_BW-1:0]  i_bsubofs,
  input  logic [DIM-1:0][CCV_BW-1:0]            i_bsub_lo_order,
  input  logic                                  i_flush,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [DIM-1:0][WBW-1:0]               o_bofs,
  output logic [VSIZE-1:0]                      o_lane_valid,
  output logic [VSIZE-1:0][DIM-1:0][WBW-1:0]    o_vector_bofs,
  output logic                                  o_last,
  output logic                                  o_done
);

  import bofs_sequencer_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  // ---------------------------------------------------------------------------
  // State and latched configuration
  // ---------------------------------------------------------------------------
  logic [1:0]                          r_state;
  logic [DIM-1:0][WBW-1:0]             r_cnt;
  logic [DIM-1:0][WBW-1:0]             r_bstart;
  logic [DIM-1:0][WBW-1:0]             r_bend;
  logic [DIM-1:0][WBW-1:0]             r_bstride;
  logic [VSIZE-1:0][DIM-1:0][CV_BW-1:0] r_subofs;
  logic [DIM-1:0][CCV_BW-1:0]          r_lo_order;

  logic [1:0]                          w_state_d;
  logic [DIM-1:0][WBW-1:0]             w_cnt_d;
  logic                                w_cfg_take;
  logic                                w_empty;
  logic                                w_valid;

  // ---------------------------------------------------------------------------
  // Odometer: innermost dimension is DIM-1; the carry ripples towards 0.
  // w_carry[j+1] is the advance request into dimension j, w_carry[0] is the
  // job-complete carry, which is also "every dimension wraps next".
  // ---------------------------------------------------------------------------
  logic [DIM:0]            w_carry;
  logic [DIM-1:0]          w_wrap;
  logic [DIM-1:0][WBW-1:0] w_cnt_adv;

  assign w_carry[DIM] = 1'b1;

  for (genvar j = 0; j < DIM; j++) begin : g_odo
    logic [WBW:0] w_sum;

    assign w_sum = {1'b0, r_cnt[j]} + {1'b0, r_bstride[j]};
    // A zero stride would never reach the boundary, so it wraps immediately.
    assign w_wrap[j] = w_sum[WBW]
                     | (w_sum[WBW-1:0] >= r_bend[j])
                     | (r_bstride[j] == '0);
    assign w_cnt_adv[j] = !w_carry[j+1] ? r_cnt[j]    :
                          w_wrap[j]     ? r_bstart[j] : w_sum[WBW-1:0];
    assign w_carry[j] = w_carry[j+1] & w_wrap[j];
  end

  // Empty job: any dimension starts at or beyond its boundary.
  always_comb begin
    w_empty = 1'b0;
    for (int unsigned j = 0; j < DIM; j++) begin
      if (i_bstart[j] >= i_bend[j]) begin
        w_empty = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_cfg_take = 1'b0;
    if (i_flush) begin
      w_state_d = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            w_cfg_take = 1'b1;
            w_cnt_d    = i_bstart;
            w_state_d  = w_empty ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_ready) begin
            w_cnt_d = w_cnt_adv;
            if (w_carry[0]) begin
              w_state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_d = ST_IDLE;
        end
        default: begin
          w_state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bstart   <= '0;
      r_bend     <= '0;
      r_bstride  <= '0;
      r_subofs   <= '0;
      r_lo_order <= '0;
    end else if (w_cfg_take) begin
      r_bstart   <= i_bstart;
      r_bend     <= i_bend;
      r_bstride  <= i_bstride;
      r_subofs   <= i_bsubofs;
      r_lo_order <= i_bsub_lo_order;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all from registers, no path from i_ready or i_cfg_valid.
  // ---------------------------------------------------------------------------
  assign w_valid     = (r_state == ST_RUN);
  assign o_valid     = w_valid;
  assign o_cfg_ready = (r_state == ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_bofs      = r_cnt;
  assign o_last      = w_valid & w_carry[0];

  bofs_lane_expand #(
    .WBW    (WBW),
    .DIM    (DIM),
    .VSIZE  (VSIZE),
    .CV_BW  (CV_BW),
    .CCV_BW (CCV_BW)
  ) u_lane_expand (
    .i_en          (w_valid),
    .i_bofs        (r_cnt),
    .i_bend        (r_bend),
    .i_subofs      (r_subofs),
    .i_lo_order    (r_lo_order),
    .o_vector_bofs (o_vector_bofs),
    .o_lane_valid  (o_lane_valid)
  );

endmodule

// File: tb/tb_bofs_sequencer.sv
module tb_bofs_sequencer;

  localparam int unsigned WBW    = 8;
  localparam int unsigned DIM    = 2;
  localparam int unsigned VSIZE  = 4;
  localparam int unsigned CV_BW  = 2;
  localparam int unsigned CCV_BW = 2;

  typedef logic [DIM-1:0][WBW-1:0]              word_vec_t;
  typedef logic [VSIZE-1:0][DIM-1:0][CV_BW-1:0] sub_t;
  typedef logic [DIM-1:0][CCV_BW-1:0]           lo_t;
  typedef logic [VSIZE-1:0][DIM-1:0][WBW-1:0]   lane_vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cfg_valid = 1'b0;
  logic       o_cfg_ready;
  word_vec_t  i_bstart = '0;
  word_vec_t  i_bend = '0;
  word_vec_t  i_bstride = '0;
  sub_t       i_bsubofs = '0;
  lo_t        i_bsub_lo_order = '0;
  logic       i_flush = 1'b0;
  logic       o_valid;
  logic       i_ready = 1'b0;
  word_vec_t  o_bofs;
  logic [VSIZE-1:0] o_lane_valid;
  lane_vec_t  o_vector_bofs;
  logic       o_last;
  logic       o_done;

  bofs_sequencer #(
    .WBW   (WBW),
    .DIM   (DIM),
    .VSIZE (VSIZE)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_cfg_valid     (i_cfg_valid),
    .o_cfg_ready     (o_cfg_ready),
    .i_bstart        (i_bstart),
    .i_bend          (i_bend),
    .i_bstride       (i_bstride),
    .i_bsubofs       (i_bsubofs),
    .i_bsub_lo_order (i_bsub_lo_order),
    .i_flush         (i_flush),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_bofs          (o_bofs),
    .o_lane_valid    (o_lane_valid),
    .o_vector_bofs   (o_vector_bofs),
    .o_last          (o_last),
    .o_done          (o_done)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a job is the cartesian product of per-dimension value
  // lists (dimension 0 outermost). Each list starts at bstart and keeps adding
  // the stride while the sum stays below the boundary; stride 0 gives one value.
  // ---------------------------------------------------------------------------
  int          m_state;          // 0 idle, 1 run, 2 done
  int unsigned m_b0[$];
  int unsigned m_b1[$];
  int          m_idx;
  bit          m_bofs_zero;
  word_vec_t   m_end;
  sub_t        m_sub;
  lo_t         m_lo;
  int unsigned vals0[$];
  int unsigned vals1[$];
  int unsigned vtmp[$];
  int unsigned done_cnt = 0;

  // Accepted beats and their side info, as seen on the DUT pins.
  int unsigned rec_b0[$];
  int unsigned rec_b1[$];
  int unsigned rec_last[$];
  int unsigned rec_lane[$];

  function automatic void dim_vals(input int unsigned st, input int unsigned en,
                                   input int unsigned sd);
    int unsigned v;
    vtmp.delete();
    v = st;
    vtmp.push_back(v);
    while (sd != 0 && (v + sd) < en) begin
      v = v + sd;
      vtmp.push_back(v);
    end
  endfunction

  function automatic void model_accept();
    bit empty;
    empty = 1'b0;
    for (int j = 0; j < DIM; j++) begin
      if (i_bstart[j] >= i_bend[j]) empty = 1'b1;
    end
    m_b0.delete();
    m_b1.delete();
    m_idx = 0;
    m_end = i_bend;
    m_sub = i_bsubofs;
    m_lo  = i_bsub_lo_order;
    m_bofs_zero = 1'b0;
    if (!empty) begin
      dim_vals(i_bstart[0], i_bend[0], i_bstride[0]);
      vals0 = vtmp;
      dim_vals(i_bstart[1], i_bend[1], i_bstride[1]);
      vals1 = vtmp;
      foreach (vals0[a]) begin
        foreach (vals1[b]) begin
          m_b0.push_back(vals0[a]);
          m_b1.push_back(vals1[b]);
        end
      end
    end
    m_state = empty ? 2 : 1;
  endfunction

  function automatic void exp_lanes(input int unsigned b0, input int unsigned b1,
                                    output logic [VSIZE-1:0] lv, output lane_vec_t vb);
    int unsigned bb[DIM];
    int unsigned v;
    bb[0] = b0;
    bb[1] = b1;
    lv = '0;
    vb = '0;
    for (int i = 0; i < VSIZE; i++) begin
      lv[i] = 1'b1;
      for (int j = 0; j < DIM; j++) begin
        v = (bb[j] | (int'(m_sub[i][j]) << m_lo[j])) & 32'hFF;
        vb[i][j] = v[WBW-1:0];
        if (!(int'(m_end[j]) > v)) lv[i] = 1'b0;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: checks every cycle on the falling edge, then steps model.
  // ---------------------------------------------------------------------------
  always @(negedge i_clk) begin
    logic [VSIZE-1:0] e_lv;
    lane_vec_t        e_vb;
    if (i_rst) begin
      chk("rst_cfg_ready", o_cfg_ready, 1);
      chk("rst_valid", o_valid, 0);
      chk("rst_done", o_done, 0);
      chk("rst_last", o_last, 0);
      chk("rst_lane_valid", o_lane_valid, 0);
      chk("rst_vector_bofs", o_vector_bofs, 0);
      chk("rst_bofs", o_bofs, 0);
      m_state = 0;
      m_b0.delete();
      m_b1.delete();
      m_idx = 0;
      m_bofs_zero = 1'b1;
    end else begin
      chk("cfg_ready", o_cfg_ready, m_state == 0);
      chk("valid", o_valid, m_state == 1);
      chk("done", o_done, m_state == 2);
      if (m_state == 1) begin
        chk("bofs_d0", o_bofs[0], m_b0[m_idx]);
        chk("bofs_d1", o_bofs[1], m_b1[m_idx]);
        chk("last", o_last, m_idx == m_b0.size() - 1);
        exp_lanes(m_b0[m_idx], m_b1[m_idx], e_lv, e_vb);
        chk("lane_valid", o_lane_valid, e_lv);
        chk("vector_bofs", o_vector_bofs, e_vb);
      end else begin
        chk("idle_last", o_last, 0);
        chk("idle_lane_valid", o_lane_valid, 0);
        chk("idle_vector_bofs", o_vector_bofs, 0);
        if (m_bofs_zero) chk("idle_bofs_zero", o_bofs, 0);
      end
      if (o_done) done_cnt++;
      if (o_valid && i_ready && !i_flush) begin
        rec_b0.push_back(o_bofs[0]);
        rec_b1.push_back(o_bofs[1]);
        rec_last.push_back(o_last);
        rec_lane.push_back(o_lane_valid);
      end
      if (i_flush) begin
        m_state = 0;
      end else begin
        case (m_state)
          0: if (i_cfg_valid) model_accept();
          1: if (i_ready) begin
               if (m_idx == m_b0.size() - 1) m_state = 2;
               else m_idx++;
             end
          default: m_state = 0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  int   rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random
  logic tog = 1'b1;

  task automatic tick();
    @(posedge i_clk);
    #1;
    case (rdy_mode)
      0: i_ready = 1'b1;
      1: begin
        i_ready = tog;
        tog = ~tog;
      end
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_rec();
    rec_b0.delete();
    rec_b1.delete();
    rec_last.delete();
    rec_lane.delete();
  endtask

  task automatic start_job(input int unsigned s0, input int unsigned s1,
                           input int unsigned e0, input int unsigned e1,
                           input int unsigned d0, input int unsigned d1,
                           input sub_t sub, input lo_t lo);
    int b;
    b = 0;
    while (!o_cfg_ready && b < 200) begin
      tick();
      b++;
    end
    chk("cfg_ready_wait", o_cfg_ready, 1);
    i_bstart[0] = WBW'(s0);
    i_bstart[1] = WBW'(s1);
    i_bend[0] = WBW'(e0);
    i_bend[1] = WBW'(e1);
    i_bstride[0] = WBW'(d0);
    i_bstride[1] = WBW'(d1);
    i_bsubofs = sub;
    i_bsub_lo_order = lo;
    i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    // Scramble inputs: the job must run from the latched copy.
    i_bstart = 16'($urandom);
    i_bend = 16'($urandom);
    i_bstride = 16'($urandom);
    i_bsubofs = 16'($urandom);
    i_bsub_lo_order = 4'($urandom);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!o_done && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!o_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no o_done within %0d cycles", budget);
    end
  endtask

  task automatic chk_beats(input string name, input int unsigned n,
                           input int unsigned e0[4], input int unsigned e1[4]);
    chk({name, "_count"}, rec_b0.size(), n);
    for (int k = 0; k < n; k++) begin
      chk({name, "_d0"}, (k < rec_b0.size()) ? rec_b0[k] : 999, e0[k]);
      chk({name, "_d1"}, (k < rec_b1.size()) ? rec_b1[k] : 999, e1[k]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int unsigned d_before;
    int unsigned exp0[4];
    int unsigned exp1[4];
    sub_t sub;
    lo_t  lo;
    int unsigned r_s[2], r_e[2], r_d[2];

    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    tick();

    // Job 1: always ready, four beats back to back, done one cycle later.
    rdy_mode = 0;
    clear_rec();
    start_job(0, 0, 2, 8, 1, 4, '0, '0);
    wait_done(100, cyc);
    chk("job1_done_latency", cyc, 4);
    exp0 = '{0, 0, 1, 1};
    exp1 = '{0, 4, 0, 4};
    chk_beats("job1", 4, exp0, exp1);
    chk("job1_last_pattern",
        {rec_last.size() > 3 ? rec_last[3][0] : 1'b0,
         rec_last.size() > 2 ? rec_last[2][0] : 1'b1,
         rec_last.size() > 1 ? rec_last[1][0] : 1'b1,
         rec_last.size() > 0 ? rec_last[0][0] : 1'b1}, 4'b1000);
    tick();
    chk("job1_cfg_ready_after", o_cfg_ready, 1);

    // Job 2: same job, ready toggling 1,0,1,0.
    rdy_mode = 1;
    tog = 1'b1;
    clear_rec();
    start_job(0, 0, 2, 8, 1, 4, '0, '0);
    wait_done(100, cyc);
    chk("job2_done_latency", cyc, 7);
    chk_beats("job2", 4, exp0, exp1);
    tick();

    // Lane mask: dim-1 sub-offsets 0..3, boundary 6 on dim 1.
    rdy_mode = 0;
    clear_rec();
    sub = '0;
    for (int i = 0; i < VSIZE; i++) sub[i][1] = CV_BW'(i);
    start_job(0, 4, 2, 6, 1, 4, sub, '0);
    wait_done(100, cyc);
    exp0 = '{0, 1, 0, 0};
    exp1 = '{4, 4, 0, 0};
    chk_beats("lane", 2, exp0, exp1);
    chk("lane_mask", rec_lane.size() > 0 ? rec_lane[0] : 99, 4'b0011);
    tick();

    // Empty job: done one cycle after acceptance, no beats.
    clear_rec();
    start_job(3, 0, 2, 8, 1, 4, '0, '0);
    chk("empty_valid", o_valid, 0);
    wait_done(100, cyc);
    chk("empty_done_latency", cyc, 0);
    chk("empty_beats", rec_b0.size(), 0);
    tick();

    // Stride 0 on dim 0.
    clear_rec();
    start_job(5, 0, 9, 8, 0, 4, '0, '0);
    wait_done(100, cyc);
    exp0 = '{5, 5, 0, 0};
    exp1 = '{0, 4, 0, 0};
    chk_beats("stride0", 2, exp0, exp1);
    chk("stride0_last", rec_last.size() > 1 ? rec_last[1] : 0, 1);
    tick();

    // Flush on the second beat.
    clear_rec();
    d_before = done_cnt;
    start_job(0, 0, 2, 8, 1, 4, '0, '0);
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_cfg_ready", o_cfg_ready, 1);
    chk("flush_valid", o_valid, 0);
    chk("flush_done", o_done, 0);
    repeat (3) tick();
    chk("flush_no_done", done_cnt, d_before);
    chk("flush_beats", rec_b0.size(), 1);

    // Asynchronous reset mid-RUN.
    d_before = done_cnt;
    start_job(0, 0, 2, 8, 1, 4, '0, '0);
    tick();
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_cfg_ready", o_cfg_ready, 1);
    chk("arst_valid", o_valid, 0);
    chk("arst_bofs", o_bofs, 0);
    chk("arst_vector", o_vector_bofs, 0);
    tick();
    i_rst = 1'b0;
    repeat (2) tick();
    chk("arst_no_done", done_cnt, d_before);
    chk("arst_idle", o_cfg_ready, 1);

    // Randomized jobs with random ready and occasional flushes.
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < DIM; j++) begin
        if ($urandom_range(0, 7) == 0) begin
          r_s[j] = 230 + $urandom_range(0, 20);
          r_e[j] = 255 - $urandom_range(0, 3);
          r_d[j] = $urandom_range(100, 200);
        end else begin
          r_s[j] = $urandom_range(0, 10);
          r_e[j] = $urandom_range(0, 16);
          r_d[j] = $urandom_range(0, 6);
        end
      end
      sub = sub_t'($urandom);
      lo  = lo_t'($urandom);
      start_job(r_s[0], r_s[1], r_e[0], r_e[1], r_d[0], r_d[1], sub, lo);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 5)) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
      end else begin
        wait_done(3000, cyc);
        tick();
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
